display_timing: RTL and testbench

- Generates 640x480@60 display raster timing for the video pipeline.
- Is the initiator side of the sprite/screen coordinate interface: it drives signed screen position (sx, sy), the active-line flag h_bright, and the pixel-clock enable consumed by every sprite renderer and the colour output stage.
- Also drives hsync/vsync to the VGA DAC and provides line/frame strobes plus a frame counter for game logic.

---
 rtl/display_timing_if.sv | 28 ++
 rtl/display_timing.sv | 124 ++++++++++++
 tb/tb_display_timing.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/display_timing_if.sv
// Screen-coordinate bus from the raster timing generator to sprite renderers,
// the colour stage and the VGA DAC. The timing generator is the master.
interface display_timing_if #(
    parameter int CORDW  = 16,
    parameter int FRAMEW = 16
);
    logic                     pix_en;
    logic signed [CORDW-1:0]  sx;
    logic signed [CORDW-1:0]  sy;
    logic                     h_bright;
    logic                     v_bright;
    logic                     bright;
    logic                     hsync;
    logic                     vsync;
    logic                     line;
    logic                     frame;
    logic [FRAMEW-1:0]        frame_cnt;

    modport master (
        output pix_en, sx, sy, h_bright, v_bright, bright,
               hsync, vsync, line, frame, frame_cnt
    );

    modport slave (
        input  pix_en, sx, sy, h_bright, v_bright, bright,
               hsync, vsync, line, frame, frame_cnt
    );
endinterface

// File: rtl/display_timing.sv
// Raster timing generator: pixel-clock enable, screen position, blanking,
// sync pulses, line/frame strobes and a frame counter. Every output is a flop.
module display_timing #(
    parameter int CORDW   = 16,
    parameter int CLK_DIV = 2,
    parameter int H_RES   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_RES   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0,
    parameter int FRAMEW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    display_timing_if.master vid_o
);
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_RES);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_RES + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_RES);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_RES + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_RES + V_FP + V_SYNC - 1);

    logic [DW-1:0]     divCnt_q, divCnt_d;
    logic              pixEn_q, pixEn_d;
    logic [HW-1:0]     hCnt_q, hCnt_d;
    logic [VW-1:0]     vCnt_q, vCnt_d;
    logic              hBright_q, hBright_d;
    logic              vBright_q, vBright_d;
    logic              bright_q, bright_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              line_q, line_d;
    logic              frame_q, frame_d;
    logic [FRAMEW-1:0] frameCnt_q, frameCnt_d;

    // Decodes use the next counter values so that every flag lines up with
    // the sx/sy that appear in the same clock.
    always_comb begin
        divCnt_d   = (divCnt_q == D_LAST) ? '0 : divCnt_q + DW'(1);
        pixEn_d    = (divCnt_d == D_LAST);
        hCnt_d     = hCnt_q;
        vCnt_d     = vCnt_q;
        frameCnt_d = frameCnt_q;
        if (pixEn_q) begin
            if (hCnt_q == H_LAST) begin
                hCnt_d = '0;
                if (vCnt_q == V_LAST) begin
                    vCnt_d     = '0;
                    frameCnt_d = frameCnt_q + FRAMEW'(1);
                end else begin
                    vCnt_d = vCnt_q + VW'(1);
                end
            end else begin
                hCnt_d = hCnt_q + HW'(1);
            end
        end
        hBright_d = (hCnt_d < H_ACT);
        vBright_d = (vCnt_d < V_ACT);
        bright_d  = hBright_d & vBright_d;
        hsync_d   = (hCnt_d >= HS_FIRST && hCnt_d <= HS_LAST) ? H_POL : ~H_POL;
        vsync_d   = (vCnt_d >= VS_FIRST && vCnt_d <= VS_LAST) ? V_POL : ~V_POL;
        line_d    = pixEn_q && (hCnt_d == '0);
        frame_d   = line_d && (vCnt_d == '0);
    end

    // Reset parks the raster on the last pixel so the first pixel enable
    // steps straight into (0,0) and begins frame 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            divCnt_q   <= '0;
            pixEn_q    <= 1'b0;
            hCnt_q     <= H_LAST;
            vCnt_q     <= V_LAST;
            hBright_q  <= 1'b0;
            vBright_q  <= 1'b0;
            bright_q   <= 1'b0;
            hsync_q    <= ~H_POL;
            vsync_q    <= ~V_POL;
            line_q     <= 1'b0;
            frame_q    <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            divCnt_q   <= divCnt_d;
            pixEn_q    <= pixEn_d;
            hCnt_q     <= hCnt_d;
            vCnt_q     <= vCnt_d;
            hBright_q  <= hBright_d;
            vBright_q  <= vBright_d;
            bright_q   <= bright_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            line_q     <= line_d;
            frame_q    <= frame_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    assign vid_o.pix_en    = pixEn_q;
    assign vid_o.sx        = CORDW'(hCnt_q);
    assign vid_o.sy        = CORDW'(vCnt_q);
    assign vid_o.h_bright  = hBright_q;
    assign vid_o.v_bright  = vBright_q;
    assign vid_o.bright    = bright_q;
    assign vid_o.hsync     = hsync_q;
    assign vid_o.vsync     = vsync_q;
    assign vid_o.line      = line_q;
    assign vid_o.frame     = frame_q;
    assign vid_o.frame_cnt = frameCnt_q;
endmodule

// File: tb/tb_display_timing.sv
// Scoreboard bench: a full 640x480 instance (CLK_DIV=2, active-low syncs) and a
// tiny raster instance (CLK_DIV=1, active-high syncs, 4-bit frame counter).
module tb_display_timing;
    typedef struct {
        int cyc; int pix; int sx; int sy; int hb; int vb; int br;
        int hs; int vs; int ln; int fr; int fc;
    } snap_t;

    typedef struct { int cyc; int sx; int sy; int fr; int fc; } line_t;

    // Small raster: H_TOTAL=15, V_TOTAL=8, frame = 120 clks
    localparam int S_HRES = 8, S_HFP = 2, S_HSYNC = 3, S_HBP = 2;
    localparam int S_VRES = 4, S_VFP = 1, S_VSYNC = 2, S_VBP = 1;

    logic clk = 1'b0;
    logic reset0 = 1'b0;
    logic reset1 = 1'b0;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;
    int   inv0 = 0;
    int   inv1 = 0;
    snap_t snapQ0[$];
    snap_t snapQ1[$];
    line_t lineQ0[$];
    line_t lineQ1[$];

    display_timing_if #(.CORDW(16), .FRAMEW(16)) if0();
    display_timing_if #(.CORDW(8),  .FRAMEW(4))  if1();

    display_timing dut0 (.clk(clk), .reset(reset0), .vid_o(if0));

    display_timing #(
        .CORDW(8), .CLK_DIV(1),
        .H_RES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
        .V_RES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
        .H_POL(1'b1), .V_POL(1'b1), .FRAMEW(4)
    ) dut1 (.clk(clk), .reset(reset1), .vid_o(if1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic string fmtSnap(snap_t s);
        return $sformatf("pix=%0d sx=%0d sy=%0d hb=%0d vb=%0d br=%0d hs=%0d vs=%0d line=%0d frame=%0d fcnt=%0d",
                         s.pix, s.sx, s.sy, s.hb, s.vb, s.br, s.hs, s.vs, s.ln, s.fr, s.fc);
    endfunction

    task automatic checkOutput(input string tag, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic checkSnap(input string tag, input snap_t exp, input snap_t act);
        nChecks++;
        if (act.pix != exp.pix || act.sx != exp.sx || act.sy != exp.sy || act.hb != exp.hb ||
            act.vb != exp.vb || act.br != exp.br || act.hs != exp.hs || act.vs != exp.vs ||
            act.ln != exp.ln || act.fr != exp.fr || act.fc != exp.fc) begin
            nFails++;
            $display("[TB] FAIL %s @cyc %0d: got {%s} expected {%s}", tag, exp.cyc, fmtSnap(act), fmtSnap(exp));
        end
    endtask

    task automatic checkLine(input string tag, input line_t exp, input line_t act);
        nChecks++;
        if (act.cyc != exp.cyc || act.sx != exp.sx || act.sy != exp.sy ||
            act.fr != exp.fr || act.fc != exp.fc) begin
            nFails++;
            $display("[TB] FAIL %s: got cyc=%0d sx=%0d sy=%0d frame=%0d fcnt=%0d expected cyc=%0d sx=%0d sy=%0d frame=%0d fcnt=%0d",
                     tag, act.cyc, act.sx, act.sy, act.fr, act.fc, exp.cyc, exp.sx, exp.sy, exp.fr, exp.fc);
        end
    endtask

    task automatic waitCyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives one instance's reset: release, assert mid-raster, optionally release again.
    task automatic applyStimulus(input int which, input int relCyc, input int rstCyc,
                                 input int rel2Cyc, input int endCyc);
        waitCyc(relCyc);
        if (which == 0) reset0 = 1'b1; else reset1 = 1'b1;
        waitCyc(rstCyc);
        if (which == 0) reset0 = 1'b0; else reset1 = 1'b0;
        if (rel2Cyc > 0) begin
            waitCyc(rel2Cyc);
            if (which == 0) reset0 = 1'b1; else reset1 = 1'b1;
        end
        waitCyc(endCyc);
    endtask

    // Expected responses for the full-size instance (base = last reset edge).
    task automatic loadDut0(input int b, input int withPreReset);
        snapQ0.push_back('{b + 0,    0, 799, 524, 0, 0, 0, 1, 1, 0, 0, 0});
        snapQ0.push_back('{b + 1,    1, 799, 524, 0, 0, 0, 1, 1, 0, 0, 0});
        snapQ0.push_back('{b + 2,    0,   0,   0, 1, 1, 1, 1, 1, 1, 1, 1});
        snapQ0.push_back('{b + 3,    1,   0,   0, 1, 1, 1, 1, 1, 0, 0, 1});
        snapQ0.push_back('{b + 1281, 1, 639,   0, 1, 1, 1, 1, 1, 0, 0, 1});
        snapQ0.push_back('{b + 1282, 0, 640,   0, 0, 1, 0, 1, 1, 0, 0, 1});
        if (withPreReset != 0) begin
            snapQ0.push_back('{b + 1313, 1, 655, 0, 0, 1, 0, 1, 1, 0, 0, 1});
            snapQ0.push_back('{b + 1314, 0, 656, 0, 0, 1, 0, 0, 1, 0, 0, 1});
            snapQ0.push_back('{b + 1505, 1, 751, 0, 0, 1, 0, 0, 1, 0, 0, 1});
            snapQ0.push_back('{b + 1506, 0, 752, 0, 0, 1, 0, 1, 1, 0, 0, 1});
            snapQ0.push_back('{b + 1601, 1, 799, 0, 0, 1, 0, 1, 1, 0, 0, 1});
        end
        snapQ0.push_back('{b + 1602, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 1});
        lineQ0.push_back('{b + 2,    0, 0, 1, 1});
        lineQ0.push_back('{b + 1602, 0, 1, 0, 1});
        if (withPreReset != 0) begin
            lineQ0.push_back('{b + 3202, 0, 2, 0, 1});
            snapQ0.push_back('{b + 3802, 0, 300, 2, 1, 1, 1, 1, 1, 0, 0, 1});
            snapQ0.push_back('{b + 3803, 0, 799, 524, 0, 0, 0, 1, 1, 0, 0, 0});
        end
    endtask

    task automatic loadDut1(input int b);
        snapQ1.push_back('{b + 0,    0, 14, 7, 0, 0, 0, 0, 0, 0, 0, 0});
        snapQ1.push_back('{b + 1,    1, 14, 7, 0, 0, 0, 0, 0, 0, 0, 0});
        snapQ1.push_back('{b + 2,    1,  0, 0, 1, 1, 1, 0, 0, 1, 1, 1});
        snapQ1.push_back('{b + 3,    1,  1, 0, 1, 1, 1, 0, 0, 0, 0, 1});
        snapQ1.push_back('{b + 12,   1, 10, 0, 0, 1, 0, 1, 0, 0, 0, 1});
        snapQ1.push_back('{b + 14,   1, 12, 0, 0, 1, 0, 1, 0, 0, 0, 1});
        snapQ1.push_back('{b + 15,   1, 13, 0, 0, 1, 0, 0, 0, 0, 0, 1});
        snapQ1.push_back('{b + 77,   1,  0, 5, 1, 0, 0, 0, 1, 1, 0, 1});
        snapQ1.push_back('{b + 106,  1, 14, 6, 0, 0, 0, 0, 1, 0, 0, 1});
        snapQ1.push_back('{b + 107,  1,  0, 7, 1, 0, 0, 0, 0, 1, 0, 1});
        snapQ1.push_back('{b + 121,  1, 14, 7, 0, 0, 0, 0, 0, 0, 0, 1});
        snapQ1.push_back('{b + 122,  1,  0, 0, 1, 1, 1, 0, 0, 1, 1, 2});
        snapQ1.push_back('{b + 1801, 1, 14, 7, 0, 0, 0, 0, 0, 0, 0, 15});
        snapQ1.push_back('{b + 1802, 1,  0, 0, 1, 1, 1, 0, 0, 1, 1, 0});
        snapQ1.push_back('{b + 1820, 1,  3, 1, 1, 1, 1, 0, 0, 0, 0, 0});
        snapQ1.push_back('{b + 1821, 0, 14, 7, 0, 0, 0, 0, 0, 0, 0, 0});
        for (int m = 0; m <= 121; m++) begin
            lineQ1.push_back('{b + 2 + 15 * m, 0, m % 8, (m % 8 == 0) ? 1 : 0, (m / 8 + 1) % 16});
        end
    endtask

    // Full-size instance: scoreboard pops plus spec-formula window checks.
    always @(negedge clk) begin : mon0
        snap_t act;
        line_t la;
        if (cyc >= 1) begin
            act = '{cyc, int'(if0.pix_en), int'(if0.sx), int'(if0.sy), int'(if0.h_bright),
                    int'(if0.v_bright), int'(if0.bright), int'(if0.hsync), int'(if0.vsync),
                    int'(if0.line), int'(if0.frame), int'(if0.frame_cnt)};
            if (snapQ0.size() > 0 && snapQ0[0].cyc == cyc) checkSnap("dut0 snapshot", snapQ0.pop_front(), act);
            if (if0.line === 1'b1) begin
                la = '{cyc, act.sx, act.sy, act.fr, act.fc};
                if (lineQ0.size() == 0) checkOutput("dut0 unexpected line strobe at cyc", cyc, -1);
                else checkLine("dut0 line event", lineQ0.pop_front(), la);
            end
            if (if0.h_bright !== (act.sx < 640)) inv0++;
            if (if0.v_bright !== (act.sy < 480)) inv0++;
            if (if0.bright !== (if0.h_bright & if0.v_bright)) inv0++;
            if (if0.hsync !== !(act.sx >= 656 && act.sx <= 751)) inv0++;
            if (if0.vsync !== !(act.sy >= 490 && act.sy <= 491)) inv0++;
            if (act.sx < 0 || act.sx > 799 || act.sy < 0 || act.sy > 524) inv0++;
            if (if0.frame === 1'b1 && if0.line !== 1'b1) inv0++;
        end
    end

    always @(negedge clk) begin : mon1
        snap_t act;
        line_t la;
        if (cyc >= 1) begin
            act = '{cyc, int'(if1.pix_en), int'(if1.sx), int'(if1.sy), int'(if1.h_bright),
                    int'(if1.v_bright), int'(if1.bright), int'(if1.hsync), int'(if1.vsync),
                    int'(if1.line), int'(if1.frame), int'(if1.frame_cnt)};
            if (snapQ1.size() > 0 && snapQ1[0].cyc == cyc) checkSnap("dut1 snapshot", snapQ1.pop_front(), act);
            if (if1.line === 1'b1) begin
                la = '{cyc, act.sx, act.sy, act.fr, act.fc};
                if (lineQ1.size() == 0) checkOutput("dut1 unexpected line strobe at cyc", cyc, -1);
                else checkLine("dut1 line event", lineQ1.pop_front(), la);
            end
            if (if1.h_bright !== (act.sx < S_HRES)) inv1++;
            if (if1.v_bright !== (act.sy < S_VRES)) inv1++;
            if (if1.bright !== (if1.h_bright & if1.v_bright)) inv1++;
            if (if1.hsync !== (act.sx >= 10 && act.sx <= 12)) inv1++;
            if (if1.vsync !== (act.sy >= 5 && act.sy <= 6)) inv1++;
            if (act.sx < 0 || act.sx > 14 || act.sy < 0 || act.sy > 7) inv1++;
            if (if1.frame === 1'b1 && if1.line !== 1'b1) inv1++;
        end
    end

    initial begin
        loadDut0(4, 1);
        loadDut0(3810, 0);
        loadDut1(6);
        fork
            applyStimulus(0, 4, 4 + 3802, 3810, 3810 + 1700);
            applyStimulus(1, 6, 6 + 1820, 0, 6 + 1830);
        join
        repeat (2) @(negedge clk);
        checkOutput("dut0 snapshots outstanding", snapQ0.size(), 0);
        checkOutput("dut0 line events outstanding", lineQ0.size(), 0);
        checkOutput("dut1 snapshots outstanding", snapQ1.size(), 0);
        checkOutput("dut1 line events outstanding", lineQ1.size(), 0);
        checkOutput("dut0 window decode errors", inv0, 0);
        checkOutput("dut1 window decode errors", inv1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
